id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
Instruction-decode stage of the 32-bit five-stage pipeline. It sits directly downstream of the fetch stage and consumes the IF/ID outputs (Next_Address, Instruction).
- Holds the 32x32 register file and decodes the MIPS subset.
- Resolves beq in ID and returns Branch_Address/PCSrc/flush to fetch.
- Detects load-use and branch hazards and drives PCWrite/hzdetect/freeze.
- Registers all operands and controls into the ID/EX pipeline register.

Parameters:
RF_DEPTH, 32, number of architectural registers (index width 5)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
Next_Address  input  32  PC+4 from IF/ID
Instruction  input  32  instruction from IF/ID
WB_RegWrite  input  1  writeback write enable
WB_Rd  input  5  writeback destination
WB_Data  input  32  writeback data
EXMEM_MemRead  input  1  load currently in MEM stage
EXMEM_Rd  input  5  destination of instruction in MEM stage
PCWrite  output  1  0 = hold PC
hzdetect  output  1  1 = hazard stall this cycle
freeze  output  1  1 = hold IF/ID
flush  output  1  1 = zero IF/ID (taken branch)
PCSrc  output  1  1 = select Branch_Address
Branch_Address  output  32  Next_Address + (sign-extended imm << 2)
IDEX_RegWrite, IDEX_MemtoReg, IDEX_MemRead, IDEX_MemWrite, IDEX_ALUSrc  output  1 each  registered controls
IDEX_ALUCtrl  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt
IDEX_Data1, IDEX_Data2, IDEX_Imm  output  32 each  registered rs value, rt value, sign-extended immediate
IDEX_Rs, IDEX_Rt, IDEX_Rd  output  5 each  registered indices; IDEX_Rd is the resolved destination (rd for R-type, rt for lw/addi)

Behaviour:
- Reset (rst=0, asynchronous): all 32 registers = 0; all IDEX_* outputs = 0.
- Decode, opcode = Instruction[31:26]:
  - 0x00 R-type, funct 0x20 add / 0x22 sub / 0x24 and / 0x25 or / 0x2A slt.
  - 0x23 lw, 0x2B sw, 0x08 addi (ALU add, ALUSrc=1), 0x04 beq.
  - Anything else, including funct not listed, decodes as NOP: all controls 0.
  - Instruction 0x00000000 is a NOP (RegWrite=0).
- Register file:
  - Two combinational read ports.
  - Write on rising clk when WB_RegWrite=1 and WB_Rd!=0.
  - R0 always reads 0.
  - Same-cycle write/read of the same nonzero register returns WB_Data (internal bypass).
- Load-use hazard: IDEX_MemRead=1, IDEX_Rd!=0, and IDEX_Rd equals the current rs, or equals rt when the instruction uses rt (R-type, sw, beq).
- Branch hazard, current instruction is beq:
  - IDEX_RegWrite=1 and IDEX_Rd!=0 matching rs/rt, or
  - EXMEM_MemRead=1 and EXMEM_Rd!=0 matching rs/rt.
- Any hazard (combinational): PCWrite=0, hzdetect=1, freeze=1, PCSrc=0, flush=0. At the next edge the ID/EX controls load 0 (bubble); data fields are don't-care but zeroed. Stall repeats each cycle until the condition clears; load-use lasts exactly 1 cycle, branch-after-load 2 cycles.
- No hazard: PCWrite=1, hzdetect=0, freeze=0. ID/EX latches the decoded values at the rising edge, giving 1-cycle latency ID to EX.
- beq, no hazard: compares rs and rt register-file values (after bypass).
  - Equal: PCSrc=1 and flush=1 in the same cycle. The beq itself enters ID/EX with all controls 0.
  - Not equal: PCSrc=0, flush=0.
- Branch_Address is always driven as Next_Address + {{14{imm[15]}}, imm, 2'b00}, with 32-bit wrap-around.
- Hazard has priority over branch resolution. flush and freeze are never both 1.
- rst asserted mid-stall clears ID/EX and the register file immediately. After release the first instruction is decoded normally.

Test Plan:
- Reset, then `addi $1,$0,5` (0x20010005) with WB writing $1=5 two cycles later -> IDEX_Imm=5, IDEX_ALUSrc=1, IDEX_Rd=1, IDEX_RegWrite=1; then a read of $1 returns 5.
- Write/read bypass: WB_RegWrite=1, WB_Rd=3, WB_Data=0xDEADBEEF while decoding `add $4,$3,$0` -> IDEX_Data1=0xDEADBEEF at the next edge.
- Load-use: `lw $2,0($1)` followed by `add $5,$2,$2` -> one cycle with PCWrite=0, hzdetect=1, freeze=1; bubble with all controls 0; the add is issued the following cycle.
- Taken beq: $1=$2=7, `beq $1,$2,+3`, Next_Address=0x100 -> Branch_Address=0x10C, PCSrc=1, flush=1; beq occupies ID/EX as a bubble.
- Branch after load: lw $6 in EX, then `beq $6,$0` -> two stall cycles (EX match, then EXMEM match), then resolves with the loaded value.
- Write to $0: WB_RegWrite=1, WB_Rd=0, WB_Data=0xFFFF -> a subsequent read of $0 returns 0. Also assert rst during a stall -> all IDEX_* = 0 immediately.

Source files
------------

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage: instruction-decode stage of the 32-bit five-stage pipeline.
//
// Holds the 32x32 register file, decodes the MIPS subset (add/sub/and/or/slt,
// lw, sw, addi, beq), resolves beq in ID and detects load-use and branch
// hazards. All operands and controls are registered into the ID/EX register.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   Next_Address          PC+4 from IF/ID
//   Instruction           instruction word from IF/ID
//   WB_RegWrite/Rd/Data   writeback port into the register file
//   EXMEM_MemRead/Rd      load currently in MEM and its destination
//   PCWrite, hzdetect,    stall controls back to fetch (combinational)
//   freeze
//   flush, PCSrc,         taken-branch redirect back to fetch (combinational)
//   Branch_Address
//   IDEX_*                registered controls, operands and register indices
// -----------------------------------------------------------------------------
module id_stage #(
  parameter int RF_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Next_Address,
  input  logic [31:0] Instruction,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_Rd,
  input  logic [31:0] WB_Data,
  input  logic        EXMEM_MemRead,
  input  logic [4:0]  EXMEM_Rd,
  output logic        PCWrite,
  output logic        hzdetect,
  output logic        freeze,
  output logic        flush,
  output logic        PCSrc,
  output logic [31:0] Branch_Address,
  output logic        IDEX_RegWrite,
  output logic        IDEX_MemtoReg,
  output logic        IDEX_MemRead,
  output logic        IDEX_MemWrite,
  output logic        IDEX_ALUSrc,
  output logic [2:0]  IDEX_ALUCtrl,
  output logic [31:0] IDEX_Data1,
  output logic [31:0] IDEX_Data2,
  output logic [31:0] IDEX_Imm,
  output logic [4:0]  IDEX_Rs,
  output logic [4:0]  IDEX_Rt,
  output logic [4:0]  IDEX_Rd
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // Instruction fields
  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [15:0] imm16_s;
  logic [31:0] imm_s;
  logic        unused_shamt_s;

  assign opcode_s = Instruction[31:26];
  assign rs_s     = Instruction[25:21];
  assign rt_s     = Instruction[20:16];
  assign rd_s     = Instruction[15:11];
  assign funct_s  = Instruction[5:0];
  assign imm16_s  = Instruction[15:0];
  assign imm_s    = {{16{imm16_s[15]}}, imm16_s};
  // shamt has no meaning in this subset
  assign unused_shamt_s = ^Instruction[10:6];

  // Decoded controls
  logic       dec_regwrite_s;
  logic       dec_memtoreg_s;
  logic       dec_memread_s;
  logic       dec_memwrite_s;
  logic       dec_alusrc_s;
  logic [2:0] dec_aluctrl_s;
  logic [4:0] dec_dest_s;
  logic       uses_rt_s;
  logic       is_beq_s;

  // Register file and read data
  logic [31:0] rf_r [RF_DEPTH];
  logic [31:0] rdata1_s;
  logic [31:0] rdata2_s;

  // Hazard / branch terms
  logic load_use_s;
  logic branch_hz_s;
  logic hazard_s;
  logic branch_taken_s;

  // ID/EX pipeline register
  logic        idex_regwrite_r;
  logic        idex_memtoreg_r;
  logic        idex_memread_r;
  logic        idex_memwrite_r;
  logic        idex_alusrc_r;
  logic [2:0]  idex_aluctrl_r;
  logic [31:0] idex_data1_r;
  logic [31:0] idex_data2_r;
  logic [31:0] idex_imm_r;
  logic [4:0]  idex_rs_r;
  logic [4:0]  idex_rt_r;
  logic [4:0]  idex_rd_r;

  // Main decoder: opcode/funct to controls; unknown encodings fall to all-zero
  always_comb begin
    dec_regwrite_s = 1'b0;
    dec_memtoreg_s = 1'b0;
    dec_memread_s  = 1'b0;
    dec_memwrite_s = 1'b0;
    dec_alusrc_s   = 1'b0;
    dec_aluctrl_s  = ALU_ADD;
    dec_dest_s     = 5'd0;
    uses_rt_s      = 1'b0;
    is_beq_s       = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        uses_rt_s = 1'b1;
        case (funct_s)
          FN_ADD: begin dec_regwrite_s = 1'b1; dec_aluctrl_s = ALU_ADD; dec_dest_s = rd_s; end
          FN_SUB: begin dec_regwrite_s = 1'b1; dec_aluctrl_s = ALU_SUB; dec_dest_s = rd_s; end
          FN_AND: begin dec_regwrite_s = 1'b1; dec_aluctrl_s = ALU_AND; dec_dest_s = rd_s; end
          FN_OR:  begin dec_regwrite_s = 1'b1; dec_aluctrl_s = ALU_OR;  dec_dest_s = rd_s; end
          FN_SLT: begin dec_regwrite_s = 1'b1; dec_aluctrl_s = ALU_SLT; dec_dest_s = rd_s; end
          default: begin end
        endcase
      end
      OP_LW: begin
        dec_regwrite_s = 1'b1;
        dec_memtoreg_s = 1'b1;
        dec_memread_s  = 1'b1;
        dec_alusrc_s   = 1'b1;
        dec_dest_s     = rt_s;
      end
      OP_SW: begin
        dec_memwrite_s = 1'b1;
        dec_alusrc_s   = 1'b1;
        uses_rt_s      = 1'b1;
      end
      OP_ADDI: begin
        dec_regwrite_s = 1'b1;
        dec_alusrc_s   = 1'b1;
        dec_dest_s     = rt_s;
      end
      OP_BEQ: begin
        // beq completes in ID, so it carries no controls into EX
        is_beq_s  = 1'b1;
        uses_rt_s = 1'b1;
      end
      default: begin end
    endcase
  end

  // Read port 1 with R0 forced to zero and same-cycle writeback bypass
  always_comb begin
    rdata1_s = 32'd0;
    if (rs_s == 5'd0) begin
      rdata1_s = 32'd0;
    end else if (WB_RegWrite && (WB_Rd == rs_s)) begin
      rdata1_s = WB_Data;
    end else begin
      rdata1_s = rf_r[rs_s];
    end
  end

  // Read port 2 with R0 forced to zero and same-cycle writeback bypass
  always_comb begin
    rdata2_s = 32'd0;
    if (rt_s == 5'd0) begin
      rdata2_s = 32'd0;
    end else if (WB_RegWrite && (WB_Rd == rt_s)) begin
      rdata2_s = WB_Data;
    end else begin
      rdata2_s = rf_r[rt_s];
    end
  end

  // Register file write; R0 is never written so it stays zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf_r[i] <= 32'd0;
      end
    end else if (WB_RegWrite && (WB_Rd != 5'd0)) begin
      rf_r[WB_Rd] <= WB_Data;
    end
  end

  // Load in EX feeding this instruction's sources
  assign load_use_s = idex_memread_r && (idex_rd_r != 5'd0) &&
                      ((idex_rd_r == rs_s) || (uses_rt_s && (idex_rd_r == rt_s)));

  // beq compares in ID, so it must wait for any producer still in EX or a load in MEM
  assign branch_hz_s = is_beq_s &&
                       ((idex_regwrite_r && (idex_rd_r != 5'd0) &&
                         ((idex_rd_r == rs_s) || (idex_rd_r == rt_s))) ||
                        (EXMEM_MemRead && (EXMEM_Rd != 5'd0) &&
                         ((EXMEM_Rd == rs_s) || (EXMEM_Rd == rt_s))));

  assign hazard_s       = load_use_s || branch_hz_s;
  assign branch_taken_s = is_beq_s && (rdata1_s == rdata2_s);
  assign Branch_Address = Next_Address + {{14{imm16_s[15]}}, imm16_s, 2'b00};

  // Fetch-side control; a stall suppresses branch resolution
  always_comb begin
    PCWrite  = 1'b1;
    hzdetect = 1'b0;
    freeze   = 1'b0;
    PCSrc    = 1'b0;
    flush    = 1'b0;
    if (hazard_s) begin
      PCWrite  = 1'b0;
      hzdetect = 1'b1;
      freeze   = 1'b1;
    end else begin
      PCSrc = branch_taken_s;
      flush = branch_taken_s;
    end
  end

  // ID/EX register: a stall inserts an all-zero bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_regwrite_r <= 1'b0;
      idex_memtoreg_r <= 1'b0;
      idex_memread_r  <= 1'b0;
      idex_memwrite_r <= 1'b0;
      idex_alusrc_r   <= 1'b0;
      idex_aluctrl_r  <= 3'd0;
      idex_data1_r    <= 32'd0;
      idex_data2_r    <= 32'd0;
      idex_imm_r      <= 32'd0;
      idex_rs_r       <= 5'd0;
      idex_rt_r       <= 5'd0;
      idex_rd_r       <= 5'd0;
    end else if (hazard_s) begin
      idex_regwrite_r <= 1'b0;
      idex_memtoreg_r <= 1'b0;
      idex_memread_r  <= 1'b0;
      idex_memwrite_r <= 1'b0;
      idex_alusrc_r   <= 1'b0;
      idex_aluctrl_r  <= 3'd0;
      idex_data1_r    <= 32'd0;
      idex_data2_r    <= 32'd0;
      idex_imm_r      <= 32'd0;
      idex_rs_r       <= 5'd0;
      idex_rt_r       <= 5'd0;
      idex_rd_r       <= 5'd0;
    end else begin
      idex_regwrite_r <= dec_regwrite_s;
      idex_memtoreg_r <= dec_memtoreg_s;
      idex_memread_r  <= dec_memread_s;
      idex_memwrite_r <= dec_memwrite_s;
      idex_alusrc_r   <= dec_alusrc_s;
      idex_aluctrl_r  <= dec_aluctrl_s;
      idex_data1_r    <= rdata1_s;
      idex_data2_r    <= rdata2_s;
      idex_imm_r      <= imm_s;
      idex_rs_r       <= rs_s;
      idex_rt_r       <= rt_s;
      idex_rd_r       <= dec_dest_s;
    end
  end

  assign IDEX_RegWrite = idex_regwrite_r;
  assign IDEX_MemtoReg = idex_memtoreg_r;
  assign IDEX_MemRead  = idex_memread_r;
  assign IDEX_MemWrite = idex_memwrite_r;
  assign IDEX_ALUSrc   = idex_alusrc_r;
  assign IDEX_ALUCtrl  = idex_aluctrl_r;
  assign IDEX_Data1    = idex_data1_r;
  assign IDEX_Data2    = idex_data2_r;
  assign IDEX_Imm      = idex_imm_r;
  assign IDEX_Rs       = idex_rs_r;
  assign IDEX_Rt       = idex_rt_r;
  assign IDEX_Rd       = idex_rd_r;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage: self-checking bench for id_stage. Directed steps follow the
// test plan, then randomized instructions are checked against a behavioural
// model (register array, ID/EX contents, hazard rules).
// -----------------------------------------------------------------------------
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Next_Address;
  logic [31:0] Instruction;
  logic        WB_RegWrite;
  logic [4:0]  WB_Rd;
  logic [31:0] WB_Data;
  logic        EXMEM_MemRead;
  logic [4:0]  EXMEM_Rd;
  logic        PCWrite, hzdetect, freeze, flush, PCSrc;
  logic [31:0] Branch_Address;
  logic        IDEX_RegWrite, IDEX_MemtoReg, IDEX_MemRead, IDEX_MemWrite, IDEX_ALUSrc;
  logic [2:0]  IDEX_ALUCtrl;
  logic [31:0] IDEX_Data1, IDEX_Data2, IDEX_Imm;
  logic [4:0]  IDEX_Rs, IDEX_Rt, IDEX_Rd;

  id_stage dut (
    .clk(clk), .rst(rst),
    .Next_Address(Next_Address), .Instruction(Instruction),
    .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .WB_Data(WB_Data),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_Rd(EXMEM_Rd),
    .PCWrite(PCWrite), .hzdetect(hzdetect), .freeze(freeze), .flush(flush),
    .PCSrc(PCSrc), .Branch_Address(Branch_Address),
    .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemtoReg(IDEX_MemtoReg),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_MemWrite(IDEX_MemWrite),
    .IDEX_ALUSrc(IDEX_ALUSrc), .IDEX_ALUCtrl(IDEX_ALUCtrl),
    .IDEX_Data1(IDEX_Data1), .IDEX_Data2(IDEX_Data2), .IDEX_Imm(IDEX_Imm),
    .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .IDEX_Rd(IDEX_Rd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] mrf [32];
  logic        m_regwrite, m_memtoreg, m_memread, m_memwrite, m_alusrc;
  logic [2:0]  m_aluctrl;
  logic [31:0] m_data1, m_data2, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  // R-type funct codes; the position in this list is the ALU code
  logic [5:0]  fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  // Combinational outputs observed during the most recent step
  logic        obs_hz, obs_pcsrc, obs_flush;
  logic [31:0] obs_ba;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    m_regwrite = 1'b0; m_memtoreg = 1'b0; m_memread = 1'b0;
    m_memwrite = 1'b0; m_alusrc = 1'b0; m_aluctrl = 3'd0;
    m_data1 = 32'd0; m_data2 = 32'd0; m_imm = 32'd0;
    m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0;
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (WB_RegWrite && (WB_Rd == a)) return WB_Data;
    return mrf[a];
  endfunction

  task automatic check_idex();
    chk("idex_regwrite", 32'(IDEX_RegWrite), 32'(m_regwrite));
    chk("idex_memtoreg", 32'(IDEX_MemtoReg), 32'(m_memtoreg));
    chk("idex_memread",  32'(IDEX_MemRead),  32'(m_memread));
    chk("idex_memwrite", 32'(IDEX_MemWrite), 32'(m_memwrite));
    chk("idex_alusrc",   32'(IDEX_ALUSrc),   32'(m_alusrc));
    chk("idex_aluctrl",  32'(IDEX_ALUCtrl),  32'(m_aluctrl));
    chk("idex_data1",    IDEX_Data1, m_data1);
    chk("idex_data2",    IDEX_Data2, m_data2);
    chk("idex_imm",      IDEX_Imm,   m_imm);
    chk("idex_rs",       32'(IDEX_Rs), 32'(m_rs));
    chk("idex_rt",       32'(IDEX_Rt), 32'(m_rt));
    chk("idex_rd",       32'(IDEX_Rd), 32'(m_rd));
  endtask

  // One pipeline cycle: drive, check fetch-side outputs, clock, check ID/EX
  task automatic step(input logic [31:0] na, input logic [31:0] ins,
                      input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd,
                      input logic exm, input logic [4:0] exrd);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, dest;
    logic [31:0] imm, a, b;
    logic        rw, mtr, mr, mw, as, uses_rt, beq, hz, taken;
    logic [2:0]  ac;
    Next_Address = na; Instruction = ins;
    WB_RegWrite = wbw; WB_Rd = wbrd; WB_Data = wbd;
    EXMEM_MemRead = exm; EXMEM_Rd = exrd;
    #1;
    op = ins[31:26]; fn = ins[5:0];
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    imm = {{16{ins[15]}}, ins[15:0]};
    rw = 1'b0; mtr = 1'b0; mr = 1'b0; mw = 1'b0; as = 1'b0; ac = 3'd0;
    uses_rt = 1'b0; beq = 1'b0;
    if (op == 6'h00) begin
      uses_rt = 1'b1;
      for (int i = 0; i < 5; i++) if (fn == fn_tab[i]) begin rw = 1'b1; ac = 3'(i); end
    end else if (op == 6'h23) begin
      rw = 1'b1; mtr = 1'b1; mr = 1'b1; as = 1'b1;
    end else if (op == 6'h2B) begin
      mw = 1'b1; as = 1'b1; uses_rt = 1'b1;
    end else if (op == 6'h08) begin
      rw = 1'b1; as = 1'b1;
    end else if (op == 6'h04) begin
      beq = 1'b1; uses_rt = 1'b1;
    end
    dest = rw ? ((op == 6'h00) ? rd : rt) : 5'd0;
    a = mread(rs); b = mread(rt);
    hz = (m_memread && m_rd != 5'd0 && (m_rd == rs || (uses_rt && m_rd == rt))) ||
         (beq && ((m_regwrite && m_rd != 5'd0 && (m_rd == rs || m_rd == rt)) ||
                  (exm && exrd != 5'd0 && (exrd == rs || exrd == rt))));
    taken = !hz && beq && (a == b);
    obs_hz = hzdetect; obs_pcsrc = PCSrc; obs_flush = flush; obs_ba = Branch_Address;
    chk("pcwrite",  32'(PCWrite),  32'(!hz));
    chk("hzdetect", 32'(hzdetect), 32'(hz));
    chk("freeze",   32'(freeze),   32'(hz));
    chk("pcsrc",    32'(PCSrc),    32'(taken));
    chk("flush",    32'(flush),    32'(taken));
    chk("branch_address", Branch_Address, na + imm * 32'd4);
    @(posedge clk);
    if (hz) begin
      m_regwrite = 1'b0; m_memtoreg = 1'b0; m_memread = 1'b0; m_memwrite = 1'b0;
      m_alusrc = 1'b0; m_aluctrl = 3'd0; m_data1 = 32'd0; m_data2 = 32'd0;
      m_imm = 32'd0; m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0;
    end else begin
      m_regwrite = rw; m_memtoreg = mtr; m_memread = mr; m_memwrite = mw;
      m_alusrc = as; m_aluctrl = ac; m_data1 = a; m_data2 = b;
      m_imm = imm; m_rs = rs; m_rt = rt; m_rd = dest;
    end
    if (wbw && wbrd != 5'd0) mrf[wbrd] = wbd;
    #1;
    check_idex();
  endtask

  initial begin
    logic [31:0] ins;
    logic [5:0]  fn;
    rst = 1'b0;
    Next_Address = 32'd0; Instruction = 32'd0;
    WB_RegWrite = 1'b0; WB_Rd = 5'd0; WB_Data = 32'd0;
    EXMEM_MemRead = 1'b0; EXMEM_Rd = 5'd0;
    model_reset();
    #12;
    check_idex();
    @(negedge clk);
    rst = 1'b1;

    // addi $1,$0,5 then writeback of $1 two cycles later, then read $1
    step(32'h4, 32'h20010005, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("addi_imm",    IDEX_Imm, 32'd5);
    chk("addi_alusrc", 32'(IDEX_ALUSrc), 32'd1);
    chk("addi_rd",     32'(IDEX_Rd), 32'd1);
    chk("addi_regwr",  32'(IDEX_RegWrite), 32'd1);
    step(32'h8, 32'h00000000, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("nop_regwr", 32'(IDEX_RegWrite), 32'd0);
    step(32'hC, 32'h00000000, 1'b1, 5'd1, 32'd5, 1'b0, 5'd0);
    step(32'h10, 32'h00203820, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("read_r1", IDEX_Data1, 32'd5);

    // Same-cycle write/read bypass
    step(32'h14, 32'h00602020, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0);
    chk("bypass_data1", IDEX_Data1, 32'hDEADBEEF);

    // Load-use: lw $2,0($1); add $5,$2,$2
    step(32'h18, 32'h8C220000, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    step(32'h1C, 32'h00422820, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("lu_stall",  32'(obs_hz), 32'd1);
    chk("lu_bubble", 32'(IDEX_RegWrite), 32'd0);
    step(32'h1C, 32'h00422820, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("lu_release", 32'(obs_hz), 32'd0);
    chk("lu_issue_rd", 32'(IDEX_Rd), 32'd5);

    // Taken beq: $1=$2=7, beq $1,$2,+3 at Next_Address 0x100
    step(32'h20, 32'h00000000, 1'b1, 5'd1, 32'd7, 1'b0, 5'd0);
    step(32'h24, 32'h00000000, 1'b1, 5'd2, 32'd7, 1'b0, 5'd0);
    step(32'h100, 32'h10220003, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("beq_target", obs_ba, 32'h10C);
    chk("beq_pcsrc",  32'(obs_pcsrc), 32'd1);
    chk("beq_flush",  32'(obs_flush), 32'd1);
    chk("beq_bubble", 32'({IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_ALUSrc}), 32'd0);

    // Branch after load: lw $6 (old $6=0x55), beq $6,$0 stalls twice then resolves
    step(32'h28, 32'h8C060000, 1'b1, 5'd6, 32'h55, 1'b0, 5'd0);
    step(32'h2C, 32'h10C00001, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("bal_stall1", 32'(obs_hz), 32'd1);
    step(32'h2C, 32'h10C00001, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
    chk("bal_stall2", 32'(obs_hz), 32'd1);
    step(32'h2C, 32'h10C00001, 1'b1, 5'd6, 32'd0, 1'b0, 5'd0);
    chk("bal_resolve", 32'(obs_hz), 32'd0);
    chk("bal_taken",   32'(obs_pcsrc), 32'd1);

    // Write to $0 is ignored
    step(32'h30, 32'h00000000, 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0);
    step(32'h34, 32'h00004020, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("r0_zero", IDEX_Data1, 32'd0);

    // Reset asserted during a load-use stall
    step(32'h38, 32'h8C220000, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    Instruction = 32'h00422820;
    #1;
    chk("rst_pre_stall", 32'(hzdetect), 32'd1);
    rst = 1'b0;
    #1;
    model_reset();
    check_idex();
    chk("rst_no_stall", 32'(hzdetect), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(32'h4, 32'h20010005, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("post_rst_rd", 32'(IDEX_Rd), 32'd1);
    step(32'h8, 32'h00203820, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("post_rst_r1", IDEX_Data1, 32'd0);

    // Randomized instruction stream against the model
    for (int n = 0; n < 300; n++) begin
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
      case ($urandom_range(0, 6))
        0: ins = {6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom), fn};
        1: ins = {6'h23, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        2: ins = {6'h2B, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        3: ins = {6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        4: ins = {6'h04, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        5: ins = $urandom;
        default: ins = 32'd0;
      endcase
      step($urandom, ins, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
